// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART parity codes, FSM state types and parity helper
package uart_pkg;

    localparam int UART_DATA_LENGTH = 8;

    localparam int UART_PARITY_NONE = 0;
    localparam int UART_PARITY_ODD  = 1;
    localparam int UART_PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    // Data is zero-extended to 9 bits; padding zeros do not change the XOR.
    function automatic logic parity_of(input logic [8:0] data, input int mode);
        return (mode == UART_PARITY_ODD) ? ~(^data) : (^data);
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - synchronous show-ahead FIFO with full/empty flags
//  clk_i, rst_n_i        clock, asynchronous active-low reset
//  push_i, data_i        write request and data (ignored when full unless popping)
//  pop_i                 read request (ignored when empty)
//  data_o                head entry, zero when empty
//  full_o, empty_o       status flags
module uart_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   PTR_ONE = (AW + 1)'(1);

    logic [AW:0]  wr_q;
    logic [AW:0]  rd_q;
    logic [W-1:0] mem [DEPTH];
    logic         do_push;
    logic         do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

    // A pop frees the slot in the same cycle, so push into a full FIFO is
    // accepted when it coincides with a pop.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + PTR_ONE;
            if (do_pop)  rd_q <= rd_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_q[AW-1:0]] <= data_i;
    end

    assign data_o = empty_o ? '0 : mem[rd_q[AW-1:0]];

endmodule

// File: rtl/uart_core.sv
// rtl/uart_core.sv - full-duplex UART with TX/RX FIFOs and integer baud divisor
//  clk_i, rst_n_i                      system clock, asynchronous active-low reset
//  rx_i, tx_o                          serial pads, idle high
//  tx_data_i, tx_data_v_i, tx_ready_o  byte stream into the TX FIFO
//  tx_busy_o                           TX FIFO non-empty or frame on the line
//  rx_data_o, rx_data_v_o, rx_ready_i  show-ahead byte stream out of the RX FIFO
//  parity_err_o, frame_err_o, overrun_o  one-cycle receive error pulses
module uart_core
    import uart_pkg::*;
#(
    parameter int DATA_W       = UART_DATA_LENGTH,
    parameter int CLKS_PER_BIT = 104,
    parameter int PARITY       = UART_PARITY_NONE,
    parameter int STOP_BITS    = 1,
    parameter int TX_DEPTH     = 16,
    parameter int RX_DEPTH     = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              rx_i,
    output logic              tx_o,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_data_v_i,
    output logic              tx_ready_o,
    output logic              tx_busy_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_data_v_o,
    input  logic              rx_ready_i,
    output logic              parity_err_o,
    output logic              frame_err_o,
    output logic              overrun_o
);

    localparam int              CW         = $clog2(CLKS_PER_BIT);
    localparam int              BW         = $clog2(DATA_W);
    localparam logic [CW-1:0]   CNT_LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]   CNT_HALF   = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]   CNT_ONE    = CW'(1);
    localparam logic [BW-1:0]   BIT_LAST   = BW'(DATA_W - 1);
    localparam logic [BW-1:0]   BIT_ONE    = BW'(1);
    localparam bit              HAS_PARITY = (PARITY != UART_PARITY_NONE);

    // Reset: asserts asynchronously, releases two clocks after rst_n_i rises.
    logic rst_meta_q;
    logic rst_n;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rst_meta_q <= 1'b0;
            rst_n      <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_n      <= rst_meta_q;
        end
    end

    // ---------------------------------------------------------------- TX
    tx_state_t         tx_state_q;
    tx_state_t         tx_state_d;
    logic [CW-1:0]     tx_cnt_q;
    logic [BW-1:0]     tx_bit_q;
    logic [DATA_W-1:0] tx_shift_q;
    logic              tx_par_q;
    logic              tx_stop_q;
    logic              tx_q;
    logic              tx_line_busy_q;
    logic              tx_tick;
    logic              tx_stop_last;
    logic              tx_pop;
    logic              tx_full;
    logic              tx_empty;
    logic [DATA_W-1:0] tx_head;

    uart_fifo #(.W(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n),
        .push_i  (tx_data_v_i),
        .data_i  (tx_data_i),
        .pop_i   (tx_pop),
        .data_o  (tx_head),
        .full_o  (tx_full),
        .empty_o (tx_empty)
    );

    assign tx_tick      = (tx_cnt_q == CNT_LAST);
    assign tx_stop_last = (STOP_BITS == 1) || tx_stop_q;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_pop     = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                if (tx_tick) tx_state_d = TX_DATA;
            end
            TX_DATA: begin
                if (tx_tick && (tx_bit_q == BIT_LAST))
                    tx_state_d = HAS_PARITY ? TX_PARITY : TX_STOP;
            end
            TX_PARITY: begin
                if (tx_tick) tx_state_d = TX_STOP;
            end
            TX_STOP: begin
                // Chain straight into the next start bit when data is waiting.
                if (tx_tick && tx_stop_last) begin
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_state_d = TX_START;
                    end else begin
                        tx_state_d = TX_IDLE;
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q     <= TX_IDLE;
            tx_cnt_q       <= '0;
            tx_bit_q       <= '0;
            tx_shift_q     <= '0;
            tx_par_q       <= 1'b0;
            tx_stop_q      <= 1'b0;
            tx_q           <= 1'b1;
            tx_line_busy_q <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            if (tx_pop) begin
                tx_cnt_q   <= '0;
                tx_bit_q   <= '0;
                tx_stop_q  <= 1'b0;
                tx_shift_q <= tx_head;
                tx_par_q   <= parity_of(9'(tx_head), PARITY);
            end else if (tx_state_q != TX_IDLE) begin
                tx_cnt_q <= tx_tick ? '0 : tx_cnt_q + CNT_ONE;
                if (tx_tick && (tx_state_q == TX_DATA)) begin
                    tx_shift_q <= tx_shift_q >> 1;
                    tx_bit_q   <= tx_bit_q + BIT_ONE;
                end
                if (tx_tick && (tx_state_q == TX_STOP)) tx_stop_q <= ~tx_stop_q;
            end
            // Line level is registered from the current state: one cycle of
            // latency on every bit, glitch-free output.
            case (tx_state_q)
                TX_START:  tx_q <= 1'b0;
                TX_DATA:   tx_q <= tx_shift_q[0];
                TX_PARITY: tx_q <= tx_par_q;
                default:   tx_q <= 1'b1;
            endcase
            tx_line_busy_q <= (tx_state_q != TX_IDLE);
        end
    end

    assign tx_o       = tx_q;
    assign tx_ready_o = !tx_full;
    assign tx_busy_o  = !tx_empty || (tx_state_q != TX_IDLE) || tx_line_busy_q;

    // ---------------------------------------------------------------- RX
    rx_state_t         rx_state_q;
    rx_state_t         rx_state_d;
    logic              rx_meta_q;
    logic              rx_sync_q;
    logic              rx_prev_q;
    logic [CW-1:0]     rx_cnt_q;
    logic [BW-1:0]     rx_bit_q;
    logic [DATA_W-1:0] rx_shift_q;
    logic              rx_par_q;
    logic              rx_tick;
    logic              rx_half;
    logic              rx_push;
    logic              rx_frame_bad;
    logic              rx_par_bad;
    logic              rx_pop;
    logic              rx_full;
    logic              rx_empty;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    assign rx_tick = (rx_cnt_q == CNT_LAST);
    assign rx_half = (rx_cnt_q == CNT_HALF);

    always_comb begin
        rx_state_d   = rx_state_q;
        rx_push      = 1'b0;
        rx_frame_bad = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_sync_q) rx_state_d = RX_START;
            end
            RX_START: begin
                // Line back high at mid start bit: a glitch, not a frame.
                if (rx_half) rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
            end
            RX_DATA: begin
                if (rx_tick && (rx_bit_q == BIT_LAST))
                    rx_state_d = HAS_PARITY ? RX_PARITY : RX_STOP;
            end
            RX_PARITY: begin
                if (rx_tick) rx_state_d = RX_STOP;
            end
            RX_STOP: begin
                if (rx_tick) begin
                    if (rx_sync_q) begin
                        rx_push    = 1'b1;
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_frame_bad = 1'b1;
                        rx_state_d   = RX_BREAK;
                    end
                end
            end
            RX_BREAK: begin
                // Hold off until the line returns high so a break is one error.
                if (rx_sync_q) rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_par_q   <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            if ((rx_state_d != rx_state_q) || rx_tick ||
                (rx_state_q == RX_IDLE) || (rx_state_q == RX_BREAK))
                rx_cnt_q <= '0;
            else
                rx_cnt_q <= rx_cnt_q + CNT_ONE;
            if (rx_state_q == RX_IDLE) rx_bit_q <= '0;
            if ((rx_state_q == RX_DATA) && rx_tick) begin
                rx_shift_q <= {rx_sync_q, rx_shift_q[DATA_W-1:1]};
                rx_bit_q   <= rx_bit_q + BIT_ONE;
            end
            if ((rx_state_q == RX_PARITY) && rx_tick) rx_par_q <= rx_sync_q;
        end
    end

    uart_fifo #(.W(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n),
        .push_i  (rx_push),
        .data_i  (rx_shift_q),
        .pop_i   (rx_ready_i),
        .data_o  (rx_data_o),
        .full_o  (rx_full),
        .empty_o (rx_empty)
    );

    assign rx_pop       = rx_ready_i && !rx_empty;
    assign rx_data_v_o  = !rx_empty;
    assign rx_par_bad   = HAS_PARITY && (rx_par_q != parity_of(9'(rx_shift_q), PARITY));
    assign parity_err_o = rx_push && rx_par_bad;
    assign frame_err_o  = rx_frame_bad;
    assign overrun_o    = rx_push && rx_full && !rx_pop;

endmodule
